// File: rtl/fwrisc_mem_pkg.sv
// Shared types for the fwrisc memory arbiter: FSM state encoding and the
// registered memory request bundle.
package fwrisc_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstb;
    logic        write;
  } mem_req_t;

  localparam mem_req_t MEM_REQ_NONE = '{addr: '0, wdata: '0, wstb: '0, write: 1'b0};

endpackage

// File: rtl/fwrisc_mem_arb_sel.sv
// Grant selection between fetch and data requests: data priority bounded by
// the consecutive-data-grant run counter.
module fwrisc_mem_arb_sel
  import fwrisc_mem_pkg::*;
#(
  parameter int unsigned MAX_DATA_RUN = 4,
  parameter int unsigned DATA_PRIO    = 1,
  parameter int unsigned RUN_W        = 3
) (
  input  logic             ivalid,
  input  logic             dvalid,
  input  logic [RUN_W-1:0] run,
  output logic             gnt_i,
  output logic             gnt_d
);

  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DATA_RUN);

  logic data_wins;

  always_comb begin
    data_wins = (DATA_PRIO != 0) && (run < RUN_MAX);
    gnt_d     = dvalid && (!ivalid || data_wins);
    gnt_i     = ivalid && !gnt_d;
  end

endmodule

// File: rtl/fwrisc_mem_arbiter.sv
// Shares one single-ported memory bus between fetch and load/store, with a
// registered memory request and combinational completion routing.
module fwrisc_mem_arbiter
  import fwrisc_mem_pkg::*;
#(
  parameter int unsigned MAX_DATA_RUN = 4,
  parameter int unsigned DATA_PRIO    = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] iaddr,
  input  logic        ivalid,
  output logic [31:0] idata,
  output logic        iready,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dwstb,
  input  logic        dwrite,
  input  logic        dvalid,
  output logic [31:0] drdata,
  output logic        dready,
  output logic [31:0] maddr,
  output logic [31:0] mwdata,
  output logic [3:0]  mwstb,
  output logic        mwrite,
  output logic        mvalid,
  input  logic [31:0] mrdata,
  input  logic        mready
);

  localparam int unsigned      RUN_W   = $clog2(MAX_DATA_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DATA_RUN);

  arb_state_e       state_q, state_d;
  mem_req_t         req_q, req_d;
  logic             mvalid_q, mvalid_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             gnt_i, gnt_d;
  logic             done;

  fwrisc_mem_arb_sel #(
    .MAX_DATA_RUN (MAX_DATA_RUN),
    .DATA_PRIO    (DATA_PRIO),
    .RUN_W        (RUN_W)
  ) u_sel (
    .ivalid (ivalid),
    .dvalid (dvalid),
    .run    (run_q),
    .gnt_i  (gnt_i),
    .gnt_d  (gnt_d)
  );

  // Completion is suppressed while reset is high so an abandoned transaction
  // can never produce a ready pulse.
  assign done = mvalid_q && mready && !reset;

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    mvalid_d = mvalid_q;
    run_d    = run_q;
    iready   = 1'b0;
    dready   = 1'b0;
    idata    = '0;
    drdata   = '0;

    unique case (state_q)
      IDLE: begin
        if (gnt_i) begin
          req_d    = '{addr: iaddr, wdata: '0, wstb: '0, write: 1'b0};
          mvalid_d = 1'b1;
          run_d    = '0;
          state_d  = BUSY_I;
        end else if (gnt_d) begin
          req_d    = '{addr: daddr, wdata: dwdata, wstb: dwstb, write: dwrite};
          mvalid_d = 1'b1;
          state_d  = BUSY_D;
          if (!ivalid)
            run_d = '0;
          else if (run_q != RUN_MAX)
            run_d = run_q + 1'b1;
        end
      end
      BUSY_I: begin
        if (done) begin
          iready   = 1'b1;
          idata    = mrdata;
          mvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      BUSY_D: begin
        if (done) begin
          dready   = 1'b1;
          drdata   = mrdata;
          mvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        mvalid_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      req_q    <= MEM_REQ_NONE;
      mvalid_q <= 1'b0;
      run_q    <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      mvalid_q <= mvalid_d;
      run_q    <= run_d;
    end
  end

  assign maddr  = req_q.addr;
  assign mwdata = req_q.wdata;
  assign mwstb  = req_q.wstb;
  assign mwrite = req_q.write;
  assign mvalid = mvalid_q;

endmodule

// File: tb/tb_fwrisc_mem_arbiter.sv
// Directed self-checking bench for fwrisc_mem_arbiter with a simple
// fixed-latency memory responder run from a single stimulus thread.
module tb_fwrisc_mem_arbiter;

  logic        clock;
  logic        reset;
  logic [31:0] iaddr;
  logic        ivalid;
  logic [31:0] idata;
  logic        iready;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  dwstb;
  logic        dwrite;
  logic        dvalid;
  logic [31:0] drdata;
  logic        dready;
  logic [31:0] maddr;
  logic [31:0] mwdata;
  logic [3:0]  mwstb;
  logic        mwrite;
  logic        mvalid;
  logic [31:0] mrdata;
  logic        mready;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  int          both_cnt = 0;
  bit          mem_auto = 1'b1;
  int          mem_lat  = 1;
  int          mem_cnt  = 0;
  logic [31:0] mem_rdata = '0;

  fwrisc_mem_arbiter #(
    .MAX_DATA_RUN (4),
    .DATA_PRIO    (1)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .iaddr  (iaddr),
    .ivalid (ivalid),
    .idata  (idata),
    .iready (iready),
    .daddr  (daddr),
    .dwdata (dwdata),
    .dwstb  (dwstb),
    .dwrite (dwrite),
    .dvalid (dvalid),
    .drdata (drdata),
    .dready (dready),
    .maddr  (maddr),
    .mwdata (mwdata),
    .mwstb  (mwstb),
    .mwrite (mwrite),
    .mvalid (mvalid),
    .mrdata (mrdata),
    .mready (mready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // One clock: the responder reacts to the registered mvalid just after the
  // edge, then outputs are sampled once the combinational paths settle.
  task automatic tick();
    @(posedge clock);
    #1;
    if (mem_auto) begin
      if (mvalid) begin
        mem_cnt++;
        mready = (mem_cnt == mem_lat);
        mrdata = mready ? mem_rdata : '0;
      end else begin
        mem_cnt = 0;
        mready  = 1'b0;
        mrdata  = '0;
      end
    end
    #1;
    if (iready && dready) both_cnt++;
  endtask

  task automatic wait_done(input string tag, input int budget, output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!(iready || dready) && cycles < budget);
    check({tag, "_done"}, 32'(iready || dready), 1);
  endtask

  initial begin
    int  cyc;
    byte order[6];
    byte exp_order[6];

    reset  = 1'b1;
    iaddr  = '0; ivalid = 1'b0;
    daddr  = '0; dwdata = '0; dwstb = '0; dwrite = 1'b0; dvalid = 1'b0;
    mrdata = '0; mready = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_mvalid", mvalid, 0);
    check("rst_maddr",  maddr,  0);
    check("rst_mwdata", mwdata, 0);
    check("rst_mwstb",  mwstb,  0);
    check("rst_mwrite", mwrite, 0);
    check("rst_iready", iready, 0);
    check("rst_dready", dready, 0);
    reset = 1'b0;
    tick();

    // Fetch only, memory answers on the second cycle of mvalid
    mem_lat = 2; mem_rdata = 32'h0000_0013;
    iaddr = 32'h100; ivalid = 1'b1;
    wait_done("t1", 10, cyc);
    check("t1_lat",    cyc,    2);
    check("t1_maddr",  maddr,  32'h100);
    check("t1_mwrite", mwrite, 0);
    check("t1_iready", iready, 1);
    check("t1_idata",  idata,  32'h13);
    check("t1_dready", dready, 0);
    ivalid = 1'b0;
    tick();
    check("t1_iready_pulse", iready, 0);
    check("t1_idata_zero",   idata,  0);
    check("t1_mvalid_clr",   mvalid, 0);
    tick();

    // Data write alone, fields held stable until mready
    mem_lat = 3; mem_rdata = 32'h1234_5678;
    daddr = 32'h2000; dwdata = 32'hDEAD_BEEF; dwstb = 4'b0011; dwrite = 1'b1; dvalid = 1'b1;
    tick();
    for (int i = 0; i < 8 && !dready; i++) begin
      check("t2_mvalid", mvalid, 1);
      check("t2_maddr",  maddr,  32'h2000);
      check("t2_mwdata", mwdata, 32'hDEAD_BEEF);
      check("t2_mwstb",  mwstb,  4'b0011);
      check("t2_mwrite", mwrite, 1);
      tick();
    end
    check("t2_dready", dready, 1);
    check("t2_drdata", drdata, 32'h1234_5678);
    check("t2_iready", iready, 0);
    dvalid = 1'b0; dwrite = 1'b0;
    tick();
    check("t2_dready_pulse", dready, 0);
    check("t2_mvalid_clr",   mvalid, 0);
    tick();

    // Simultaneous requests: data first, fetch granted two edges later
    mem_lat = 1; mem_rdata = 32'h55;
    iaddr = 32'h300; ivalid = 1'b1;
    daddr = 32'h400; dvalid = 1'b1;
    wait_done("t3d", 10, cyc);
    check("t3_first_d", dready, 1);
    check("t3_drdata",  drdata, 32'h55);
    check("t3_no_i",    iready, 0);
    dvalid = 1'b0;
    tick();
    check("t3_bubble", mvalid, 0);
    tick();
    check("t3_i_gnt",   mvalid, 1);
    check("t3_i_addr",  maddr,  32'h300);
    check("t3_i_write", mwrite, 0);
    wait_done("t3i", 10, cyc);
    check("t3_iready", iready, 1);
    ivalid = 1'b0;
    tick(); tick();

    // Starvation guard: fetch forced after four contended data grants
    mem_lat = 1;
    iaddr = 32'h500; ivalid = 1'b1;
    daddr = 32'h600; dvalid = 1'b1; dwrite = 1'b0;
    exp_order = '{"D", "D", "D", "D", "I", "D"};
    for (int g = 0; g < 6; g++) begin
      wait_done($sformatf("t4_%0d", g), 10, cyc);
      order[g] = iready ? "I" : "D";
      if (iready) ivalid = 1'b0;
    end
    dvalid = 1'b0;
    for (int g = 0; g < 6; g++)
      check($sformatf("t4_order%0d", g), 32'(order[g]), 32'(exp_order[g]));
    tick(); tick();

    // Reset while BUSY_D, mready arrives the cycle after reset
    mem_auto = 1'b0; mready = 1'b0;
    daddr = 32'h800; dvalid = 1'b1;
    tick();
    check("t5_busy", mvalid, 1);
    dvalid = 1'b0;
    reset  = 1'b1;
    tick();
    check("t5_mvalid_rst", mvalid, 0);
    check("t5_dready_rst", dready, 0);
    reset = 1'b0; mready = 1'b1; mrdata = 32'hAA;
    #1;
    check("t5_late_dready", dready, 0);
    check("t5_late_iready", iready, 0);
    tick();
    check("t5_idle", mvalid, 0);
    check("t5_idle_dready", dready, 0);

    // Spurious mready while idle (still held from above)
    check("t6_iready", iready, 0);
    check("t6_drdata", drdata, 0);
    tick();
    check("t6_mvalid", mvalid, 0);
    mready = 1'b0; mrdata = '0;
    mem_auto = 1'b1;
    tick();

    check("ready_exclusive", both_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
